// File: rtl/stoch_layer_if.sv
`default_nettype none
// ============================================================================
// stoch_layer_if : binary-domain start/done bus of the sequenced SC layer
// Revision: 1.0
// ============================================================================
interface stoch_layer_if #(
   parameter int INPUT_SIZE   = 2,
   parameter int NEURON_COUNT = 2,
   parameter int BITS         = 8,
   parameter int CW           = 9
);
   logic                                 start;
   logic [INPUT_SIZE*BITS-1:0]           in_value;
   logic [NEURON_COUNT*INPUT_SIZE*BITS-1:0] weights;
   logic [NEURON_COUNT*BITS-1:0]         bias;
   logic                                 busy;
   logic                                 done;
   logic [NEURON_COUNT*CW-1:0]           out_value;

   modport master (
      output start, in_value, weights, bias,
      input  busy, done, out_value
   );

   modport slave (
      input  start, in_value, weights, bias,
      output busy, done, out_value
   );
endinterface
`default_nettype wire

// File: rtl/stoch_layer_seq.sv
`default_nettype none
// ============================================================================
// stoch_layer_seq : sequenced stochastic-computing layer, binary in / counts out
// Optional stochastic-tanh output stage: define STOCH_LAYER_STANH_EN
// Revision: 1.0
// ============================================================================
module stoch_layer_seq #(
   parameter int INPUT_SIZE   = 2,
   parameter int NEURON_COUNT = 2,
   parameter int BITS         = 8,
   parameter int STREAM_LEN   = 256,
   parameter int SEED         = 0,
   parameter int STATES       = 8
) (
   input  logic         clk,
   input  logic         rst,
   stoch_layer_if.slave bus
);
   localparam int CW   = $clog2(STREAM_LEN + 1);
   localparam int SW   = $clog2(INPUT_SIZE + 1);
   localparam int NW   = NEURON_COUNT * INPUT_SIZE;
   localparam int NSNG = INPUT_SIZE + NW + NEURON_COUNT;

   if (BITS < 2 || BITS > 16 || STREAM_LEN < 1 || STATES < 2 || (STATES % 2) != 0) begin : g_bad_param
      $error("stoch_layer_seq: illegal parameter set");
   end

   // Maximal-length Fibonacci tap masks, bit (t-1) set for tap t
   function automatic logic [15:0] tap_mask(input int n);
      case (n)
         2:       return 16'h0003;
         3:       return 16'h0006;
         4:       return 16'h000C;
         5:       return 16'h0014;
         6:       return 16'h0030;
         7:       return 16'h0060;
         8:       return 16'h00B8;
         9:       return 16'h0110;
         10:      return 16'h0240;
         11:      return 16'h0500;
         12:      return 16'h0829;
         13:      return 16'h100D;
         14:      return 16'h2015;
         15:      return 16'h6000;
         16:      return 16'hD008;
         default: return 16'h0000;
      endcase
   endfunction

   localparam logic [15:0]     TAPS16 = tap_mask(BITS);
   localparam logic [BITS-1:0] TAPS   = TAPS16[BITS-1:0];

   function automatic logic [BITS-1:0] lfsr_step(input logic [BITS-1:0] v);
      return {v[BITS-2:0], ^(v & TAPS)};
   endfunction

   function automatic logic [BITS-1:0] seed_of(input int k);
      return BITS'(((SEED + k) % ((1 << BITS) - 1)) + 1);
   endfunction

   typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t                     state_q, state_d;
   logic [CW-1:0]              cyc_q, cyc_d;
   logic [SW-1:0]              sel_q, sel_d;
   logic [NSNG*BITS-1:0]       vals_q, vals_d;
   logic [BITS-1:0]            lfsr_q [NSNG];
   logic [BITS-1:0]            lfsr_d [NSNG];
   logic [CW-1:0]              cnt_q [NEURON_COUNT];
   logic [CW-1:0]              cnt_d [NEURON_COUNT];
   logic [NEURON_COUNT*CW-1:0] out_q, out_d;
   logic                       done_q, done_d;

   logic [NSNG-1:0]            sbit;
   logic [NEURON_COUNT-1:0]    mux_bit;
   logic [NEURON_COUNT-1:0]    nbit;

   // Latched values share one vector in SNG index order: inputs, weights, biases
   for (genvar k = 0; k < NSNG; k++) begin : g_sng
      assign sbit[k] = (vals_q[k*BITS +: BITS] > lfsr_q[k]);
   end

   for (genvar n = 0; n < NEURON_COUNT; n++) begin : g_neuron
      logic [INPUT_SIZE:0] term;
      for (genvar i = 0; i < INPUT_SIZE; i++) begin : g_prod
         assign term[i] = ~(sbit[i] ^ sbit[INPUT_SIZE + n*INPUT_SIZE + i]);
      end
      assign term[INPUT_SIZE] = sbit[INPUT_SIZE + NW + n];
      assign mux_bit[n]       = term[sel_q];
   end

`ifdef STOCH_LAYER_STANH_EN
   localparam int            SSW  = (STATES > 2) ? $clog2(STATES) : 1;
   localparam logic [SSW-1:0] HALF = SSW'(STATES / 2);
   localparam logic [SSW-1:0] TOP  = SSW'(STATES - 1);

   logic [SSW-1:0] fsm_q [NEURON_COUNT];
   logic [SSW-1:0] fsm_d [NEURON_COUNT];

   for (genvar n = 0; n < NEURON_COUNT; n++) begin : g_stanh
      assign nbit[n] = (fsm_q[n] >= HALF);
   end
`else
   assign nbit = mux_bit;
`endif

   always_comb begin
      state_d = state_q;
      cyc_d   = cyc_q;
      sel_d   = sel_q;
      vals_d  = vals_q;
      lfsr_d  = lfsr_q;
      cnt_d   = cnt_q;
      out_d   = out_q;
      done_d  = 1'b0;
`ifdef STOCH_LAYER_STANH_EN
      fsm_d   = fsm_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = RUN;
               vals_d  = {bus.bias, bus.weights, bus.in_value};
               cyc_d   = '0;
               sel_d   = '0;
               for (int k = 0; k < NSNG; k++) lfsr_d[k] = seed_of(k);
               for (int n = 0; n < NEURON_COUNT; n++) begin
                  cnt_d[n] = '0;
`ifdef STOCH_LAYER_STANH_EN
                  fsm_d[n] = HALF;
`endif
               end
            end
         end
         RUN: begin
            for (int k = 0; k < NSNG; k++) lfsr_d[k] = lfsr_step(lfsr_q[k]);
            sel_d = (sel_q == SW'(INPUT_SIZE)) ? '0 : sel_q + SW'(1);
            cyc_d = cyc_q + CW'(1);
            for (int n = 0; n < NEURON_COUNT; n++) begin
               cnt_d[n] = cnt_q[n] + CW'(nbit[n]);
`ifdef STOCH_LAYER_STANH_EN
               if (mux_bit[n] && fsm_q[n] != TOP)
                  fsm_d[n] = fsm_q[n] + SSW'(1);
               else if (!mux_bit[n] && fsm_q[n] != '0)
                  fsm_d[n] = fsm_q[n] - SSW'(1);
`endif
            end
            // Final cycle's bit is included in the published count
            if (cyc_q == CW'(STREAM_LEN - 1)) begin
               state_d = IDLE;
               done_d  = 1'b1;
               for (int n = 0; n < NEURON_COUNT; n++) out_d[n*CW +: CW] = cnt_d[n];
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cyc_q   <= '0;
         sel_q   <= '0;
         vals_q  <= '0;
         out_q   <= '0;
         done_q  <= 1'b0;
         for (int k = 0; k < NSNG; k++) lfsr_q[k] <= '0;
         for (int n = 0; n < NEURON_COUNT; n++) begin
            cnt_q[n] <= '0;
`ifdef STOCH_LAYER_STANH_EN
            fsm_q[n] <= '0;
`endif
         end
      end else begin
         state_q <= state_d;
         cyc_q   <= cyc_d;
         sel_q   <= sel_d;
         vals_q  <= vals_d;
         out_q   <= out_d;
         done_q  <= done_d;
         lfsr_q  <= lfsr_d;
         cnt_q   <= cnt_d;
`ifdef STOCH_LAYER_STANH_EN
         fsm_q   <= fsm_d;
`endif
      end
   end

   assign bus.busy      = (state_q == RUN);
   assign bus.done      = done_q;
   assign bus.out_value = out_q;

endmodule
`default_nettype wire

// File: tb/tb_stoch_layer_seq.sv
`default_nettype none
// ============================================================================
// tb_stoch_layer_seq : vector table + scoreboard bench for stoch_layer_seq
// Revision: 1.0
// ============================================================================
module tb_stoch_layer_seq;
   localparam int INS = 2;
   localparam int NC  = 2;
   localparam int B   = 8;
   localparam int SL  = 256;
   localparam int CW  = $clog2(SL + 1);
   localparam int LAT = SL + 1;

   logic clk;
   logic rst;

   stoch_layer_if #(.INPUT_SIZE(INS), .NEURON_COUNT(NC), .BITS(B), .CW(CW)) bus ();

   stoch_layer_seq #(
      .INPUT_SIZE(INS), .NEURON_COUNT(NC), .BITS(B),
      .STREAM_LEN(SL), .SEED(0), .STATES(8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int lo;
      int hi;
   } exp_t;

   typedef struct {
      logic [INS*B-1:0]    iv;
      logic [NC*INS*B-1:0] wv;
      logic [NC*B-1:0]     bv;
      int                  lo;
      int                  hi;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[4];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic check_eq(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic check_rng(input string name, input int act, input int lo, input int hi);
      n_cmp++;
      if (act < lo || act > hi) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   // Scoreboard consumer: every done pulse must match the oldest pending epoch
   always @(negedge clk) begin
      if (!rst && bus.done) begin
         if (sb.size() == 0) begin
            check_eq("unexpected done", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            for (int n = 0; n < NC; n++)
               check_rng($sformatf("count n%0d", n), int'(bus.out_value[n*CW +: CW]), e.lo, e.hi);
         end
      end
   end

   task automatic launch(input vec_t v);
      exp_t e;
      @(negedge clk);
      bus.in_value = v.iv;
      bus.weights  = v.wv;
      bus.bias     = v.bv;
      bus.start    = 1'b1;
      e.lo = v.lo;
      e.hi = v.hi;
      sb.push_back(e);
      @(posedge clk);
   endtask

   // Called right after the accepting edge; k = cycles until done is visible
   task automatic wait_done(input int poke_k, input bit hold, output int k);
      bit seen;
      seen = 1'b0;
      k    = 0;
      while (!seen && k < LAT + 100) begin
         @(negedge clk);
         k++;
         if (k == 1) begin
            if (!hold) bus.start = 1'b0;
            check_eq("busy after start", int'(bus.busy), 1);
         end
         if (poke_k != 0 && k == poke_k) begin
            bus.start    = 1'b1;
            bus.in_value = '1;
         end
         if (poke_k != 0 && k == poke_k + 1) bus.start = 1'b0;
         if (bus.done) seen = 1'b1;
      end
      if (!seen) check_eq("done timeout", 0, 1);
      else       check_eq("busy in done cycle", int'(bus.busy), 0);
   endtask

   initial begin
      int  k;
      bit  saw_done;

`ifdef STOCH_LAYER_STANH_EN
      vecs[0] = '{iv: '0, wv: '0, bv: '0, lo: 256, hi: 256};
      vecs[1] = '{iv: '1, wv: '1, bv: '1, lo: 250, hi: 256};
      vecs[2] = '{iv: '0, wv: '1, bv: '0, lo: 0,   hi: 6};
      vecs[3] = '{iv: '1, wv: '0, bv: '1, lo: 0,   hi: 6};
`else
      vecs[0] = '{iv: '0, wv: '0, bv: '0, lo: 171, hi: 171};
      vecs[1] = '{iv: '1, wv: '1, bv: '1, lo: 250, hi: 256};
      vecs[2] = '{iv: '0, wv: '1, bv: '0, lo: 0,   hi: 6};
      vecs[3] = '{iv: '1, wv: '0, bv: '1, lo: 79,  hi: 91};
`endif

      rst          = 1'b1;
      bus.start    = 1'b0;
      bus.in_value = '0;
      bus.weights  = '0;
      bus.bias     = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("reset busy", int'(bus.busy), 0);
      check_eq("reset done", int'(bus.done), 0);
      check_eq("reset out_value", int'(bus.out_value), 0);
      rst = 1'b0;

      for (int i = 0; i < 4; i++) begin
         launch(vecs[i]);
         wait_done(0, 1'b0, k);
         check_eq($sformatf("latency vec%0d", i), k, LAT);
      end

      // start and new inputs mid-epoch are ignored
      launch(vecs[0]);
      wait_done(50, 1'b0, k);
      check_eq("latency with mid-run start", k, LAT);

      // reset aborts an epoch and clears the result
      launch(vecs[0]);
      repeat (100) begin
         @(negedge clk);
         bus.start = 1'b0;
      end
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_eq("abort busy", int'(bus.busy), 0);
      check_eq("abort done", int'(bus.done), 0);
      check_eq("abort out_value", int'(bus.out_value), 0);
      sb.delete();
      rst      = 1'b0;
      saw_done = 1'b0;
      repeat (300) begin
         @(negedge clk);
         if (bus.done) saw_done = 1'b1;
      end
      check_eq("no done after abort", int'(saw_done), 0);
      launch(vecs[0]);
      wait_done(0, 1'b0, k);
      check_eq("latency after abort", k, LAT);

      // start held through done: back-to-back epochs
      launch(vecs[0]);
      wait_done(0, 1'b1, k);
      check_eq("latency back-to-back 1", k, LAT);
      begin
         exp_t e;
         e.lo = vecs[0].lo;
         e.hi = vecs[0].hi;
         sb.push_back(e);
      end
      @(posedge clk);
      wait_done(0, 1'b0, k);
      check_eq("latency back-to-back 2", k, LAT);

      repeat (5) @(negedge clk);
      check_eq("scoreboard drained", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
`default_nettype wire
